mac_layer_scheduler: RTL and testbench
======================================

// Module: mac_layer_scheduler
// PURPOSE
//  Sequences one shared MAC accumulator datapath across NUM_NEURONS neurons of a dense layer.
//  Per neuron: clears the accumulator, streams VEC_LEN (x, w) pairs from input/weight RAMs, then
//  requantises the result (shift, saturate, optional ReLU) and emits it on a valid/ready port.
//  Sits between the layer buffers and the MAC neuron; one start runs the whole layer.
// PARAMETERS
//  DATA_W       8   signed width of x and w samples
//  ACC_W        16  signed width of MAC accumulator (mac_acc)
//  VEC_LEN      3   inputs per neuron, >=1
//  NUM_NEURONS  4   neurons per layer, >=1
//  OUT_W        8   signed width of out_data
//  SHIFT        0   arithmetic right shift applied to mac_acc before saturation
//  RELU_EN      1   1: negative results forced to 0
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous active-low reset
//  start      in   1                  begin layer; sampled only in IDLE
//  busy       out  1                  high in every state except IDLE
//  done       out  1                  one-cycle pulse after last neuron's output accepted
//  rd_en      out  1                  RAM read strobe; RAM data valid next cycle
//  x_addr     out  max(1,clog2(VEC_LEN))              input RAM address
//  w_addr     out  max(1,clog2(VEC_LEN*NUM_NEURONS))  weight RAM address
//  x_rdata    in   DATA_W             input RAM data (1-cycle read latency)
//  w_rdata    in   DATA_W             weight RAM data (1-cycle read latency)
//  mac_clr    out  1                  MAC: acc <= 0 at next edge
//  mac_en     out  1                  MAC: acc <= acc + mac_x*mac_w at next edge
//  mac_x      out  DATA_W             = x_rdata (pass-through)
//  mac_w      out  DATA_W             = w_rdata (pass-through)
//  mac_acc    in   ACC_W              MAC accumulator value
//  out_valid  out  1                  out_data/out_idx valid
//  out_ready  in   1                  consumer accepts when valid&ready
//  out_data   out  OUT_W              requantised neuron result
//  out_idx    out  max(1,clog2(NUM_NEURONS))  neuron index of out_data
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, done, rd_en, mac_clr, mac_en, out_valid = 0;
//   addresses, out_data, out_idx, neuron/input counters = 0.
//  FSM (registered state, Moore outputs):
//   IDLE   : start=1 -> CLEAR, n=0. start=0 stays.
//   CLEAR  : mac_clr=1, i=0 -> ISSUE.
//   ISSUE  : rd_en=1, x_addr=i, w_addr=n*VEC_LEN+i; i++; at i==VEC_LEN-1 -> WAIT.
//   WAIT   : no read; last mac_en beat -> SETTLE.
//   SETTLE : mac_acc final; out_data <= requant(mac_acc), out_idx <= n -> OUT.
//   OUT    : out_valid=1; on out_ready: n==NUM_NEURONS-1 -> DONE, else n++ -> CLEAR.
//   DONE   : done=1 for one cycle -> IDLE.
//  mac_en is rd_en delayed one register stage (exactly VEC_LEN beats per neuron, never in CLEAR).
//  mac_clr and mac_en never high in the same cycle.
//  Latency: start sampled at edge E -> out_valid high from cycle E+VEC_LEN+4 (VEC_LEN=3: 7 cycles).
//  Per-neuron overhead with out_ready held 1: VEC_LEN+4 cycles; done one cycle after final handshake.
//  Requant: t = mac_acc >>> SHIFT (sign-preserving); saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
//   then RELU_EN=1 & t<0 -> 0. Computed at full ACC_W width, no intermediate wrap.
//  Handshake: out_data/out_idx/out_valid stable while out_valid & !out_ready; no bubble rule beyond FSM.
//  start while busy: ignored, no effect on counters. start held high through DONE: new layer starts
//   only after return to IDLE (next edge after DONE).
//  Reset mid-layer: abort immediately; partial result discarded; no done pulse.
// TESTING
//  1 VEC_LEN=3,N=1: x={2,3,4}, w={5,6,7}, out_ready=1 -> out_data=56, out_idx=0, out_valid at E+7, done next.
//  2 N=4, w row n = {n+1,n+1,n+1}, x={1,1,1} -> outputs 3,6,9,12 in order, idx 0..3, single done pulse.
//  3 x={100,100,100}, w={100,100,100} (acc 30000) -> out_data=127; negate w, RELU_EN=0 -> -128; RELU_EN=1 -> 0.
//  4 out_ready low 5 cycles in OUT -> out_valid/out_data/out_idx held; no rd_en/mac_en until accepted.
//  5 start pulsed during ISSUE, and rst_n low in WAIT -> start ignored; reset forces IDLE, all outputs 0.
//  6 Check per cycle: mac_en==past(rd_en), w_addr==n*VEC_LEN+i, mac_clr once per neuron, never with mac_en.

Source files
------------

// File: rtl/mac_layer_scheduler.sv
// Sequences one shared MAC accumulator across the neurons of a dense layer:
// clear, stream VEC_LEN (x, w) pairs, requantise, and hand the result out on valid/ready.
module mac_layer_scheduler #(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 16,
  parameter int VEC_LEN     = 3,
  parameter int NUM_NEURONS = 4,
  parameter int OUT_W       = 8,
  parameter int SHIFT       = 0,
  parameter int RELU_EN     = 1,
  localparam int XA_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
  localparam int WA_W = (VEC_LEN * NUM_NEURONS > 1) ? $clog2(VEC_LEN * NUM_NEURONS) : 1,
  localparam int NI_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [XA_W-1:0]   x_addr,
  output logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] x_rdata,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_x,
  output logic [DATA_W-1:0] mac_w,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [NI_W-1:0]   out_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_OUT,
    S_DONE
  } state_e;

  // One guard bit above the wider of ACC_W/OUT_W keeps the saturation compare wrap-free.
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_e            state_q, state_d;
  logic [XA_W-1:0]   i_q, i_d;
  logic [NI_W-1:0]   n_q, n_d;
  logic [WA_W-1:0]   wbase_q, wbase_d;
  logic              mac_en_q;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [NI_W-1:0]   out_idx_q, out_idx_d;

  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] shifted;
  logic [OUT_W-1:0]        requant;

  assign acc_ext = {{(EXT_W-ACC_W){mac_acc[ACC_W-1]}}, mac_acc};
  assign shifted = acc_ext >>> SHIFT;

  always_comb begin
    requant = shifted[OUT_W-1:0];
    if ((RELU_EN != 0) && shifted[EXT_W-1]) begin
      requant = '0;
    end else if (shifted > SAT_MAX) begin
      requant = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      requant = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      n_q        <= '0;
      wbase_q    <= '0;
      mac_en_q   <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      n_q        <= n_d;
      wbase_q    <= wbase_d;
      mac_en_q   <= rd_en;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    n_d        = n_q;
    wbase_d    = wbase_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    busy       = 1'b1;
    done       = 1'b0;
    rd_en      = 1'b0;
    mac_clr    = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          n_d     = '0;
          wbase_d = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clr = 1'b1;
        i_d     = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        rd_en = 1'b1;
        if (i_q == XA_W'(VEC_LEN - 1)) begin
          i_d     = '0;
          state_d = S_WAIT;
        end else begin
          i_d = i_q + XA_W'(1);
        end
      end
      // The final mac_en beat always lands here, one cycle behind the last read.
      S_WAIT: state_d = S_SETTLE;
      S_SETTLE: begin
        out_data_d = requant;
        out_idx_d  = n_q;
        state_d    = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (n_q == NI_W'(NUM_NEURONS - 1)) begin
            state_d = S_DONE;
          end else begin
            n_d     = n_q + NI_W'(1);
            wbase_d = wbase_q + WA_W'(VEC_LEN);
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x_addr   = i_q;
  assign w_addr   = wbase_q + WA_W'(i_q);
  assign mac_en   = mac_en_q;
  assign mac_x    = x_rdata;
  assign mac_w    = w_rdata;
  assign out_data = out_data_q;
  assign out_idx  = out_idx_q;

endmodule

// File: tb/tb_mac_layer_scheduler.sv
// Bench for mac_layer_scheduler: two instances (4 neurons with ReLU, 1 neuron without),
// each wrapped with a 1-cycle-latency RAM model and a MAC accumulator model.
module tb_mac_layer_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [7:0] x_mem [0:3];
  logic signed [7:0] w_mem [0:15];

  // Instance A: NUM_NEURONS=4, RELU_EN=1
  logic        start_a, busy_a, done_a, rd_en_a, mac_clr_a, mac_en_a, out_valid_a, out_ready_a;
  logic [1:0]  x_addr_a, out_idx_a;
  logic [3:0]  w_addr_a;
  logic [7:0]  x_rdata_a, w_rdata_a, mac_x_a, mac_w_a, out_data_a;
  logic [15:0] mac_acc_a;
  logic signed [15:0] prod_a;

  // Instance B: NUM_NEURONS=1, RELU_EN=0
  logic        start_b, busy_b, done_b, rd_en_b, mac_clr_b, mac_en_b, out_valid_b, out_ready_b;
  logic [1:0]  x_addr_b, w_addr_b;
  logic [0:0]  out_idx_b;
  logic [7:0]  x_rdata_b, w_rdata_b, mac_x_b, mac_w_b, out_data_b;
  logic [15:0] mac_acc_b;
  logic signed [15:0] prod_b;

  mac_layer_scheduler #(.NUM_NEURONS(4), .RELU_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .x_addr(x_addr_a), .w_addr(w_addr_a),
    .x_rdata(x_rdata_a), .w_rdata(w_rdata_a), .mac_clr(mac_clr_a), .mac_en(mac_en_a),
    .mac_x(mac_x_a), .mac_w(mac_w_a), .mac_acc(mac_acc_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .out_idx(out_idx_a)
  );

  mac_layer_scheduler #(.NUM_NEURONS(1), .RELU_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .x_addr(x_addr_b), .w_addr(w_addr_b),
    .x_rdata(x_rdata_b), .w_rdata(w_rdata_b), .mac_clr(mac_clr_b), .mac_en(mac_en_b),
    .mac_x(mac_x_b), .mac_w(mac_w_b), .mac_acc(mac_acc_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_idx(out_idx_b)
  );

  assign prod_a = $signed(mac_x_a) * $signed(mac_w_a);
  assign prod_b = $signed(mac_x_b) * $signed(mac_w_b);

  always_ff @(posedge clk) begin
    if (rd_en_a) begin
      x_rdata_a <= x_mem[x_addr_a];
      w_rdata_a <= w_mem[w_addr_a];
    end
    if (rd_en_b) begin
      x_rdata_b <= x_mem[x_addr_b];
      w_rdata_b <= w_mem[{2'b00, w_addr_b}];
    end
    if (!rst_n || mac_clr_a) mac_acc_a <= '0;
    else if (mac_en_a)       mac_acc_a <= mac_acc_a + prod_a;
    if (!rst_n || mac_clr_b) mac_acc_b <= '0;
    else if (mac_en_b)       mac_acc_b <= mac_acc_b + prod_b;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic ov(input bit b); return b ? out_valid_b : out_valid_a; endfunction
  function automatic logic dn(input bit b); return b ? done_b : done_a; endfunction
  function automatic logic by(input bit b); return b ? busy_b : busy_a; endfunction
  function automatic int od(input bit b);
    return b ? int'($signed(out_data_b)) : int'($signed(out_data_a));
  endfunction
  function automatic int oi(input bit b);
    return b ? int'(out_idx_b) : int'(out_idx_a);
  endfunction

  // Per-cycle protocol model for instance A: read pipeline, addressing, clear count.
  logic prev_rd;
  int   n_m, i_m, clr_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 1'b0; n_m = 0; i_m = 0; clr_cnt = 0;
    end else begin
      check("mac_en_pipe", mac_en_a, prev_rd);
      check("clr_en_excl", mac_clr_a & mac_en_a, 0);
      if (mac_clr_a) begin
        i_m = 0;
        clr_cnt++;
      end
      if (rd_en_a) begin
        check("x_addr", x_addr_a, i_m);
        check("w_addr", w_addr_a, n_m * 3 + i_m);
        i_m++;
      end
      if (out_valid_a && out_ready_a) n_m++;
      if (done_a) begin
        check("clr_per_layer", clr_cnt, 4);
        n_m = 0;
        clr_cnt = 0;
      end
      prev_rd = rd_en_a;
    end
  end

  task automatic load(input int x0, x1, x2, w0, w1, w2);
    x_mem[0] = 8'(x0); x_mem[1] = 8'(x1); x_mem[2] = 8'(x2); x_mem[3] = '0;
    for (int r = 0; r < 4; r++) begin
      w_mem[r*3]   = 8'(w0);
      w_mem[r*3+1] = 8'(w1);
      w_mem[r*3+2] = 8'(w2);
    end
    for (int r = 12; r < 16; r++) w_mem[r] = '0;
  endtask

  // Called at a negedge k0 cycles after start was sampled; OUT must appear at cycle 7.
  task automatic expect_out(input bit b, input string tag, input int k0, input int exp_d, input int exp_i);
    int k = k0;
    while (!ov(b) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, ov(b), 1);
    check({tag, "_lat"}, k, 7);
    check({tag, "_data"}, od(b), exp_d);
    check({tag, "_idx"}, oi(b), exp_i);
    $display("out %s data=%0d idx=%0d cyc=%0d", tag, od(b), oi(b), k);
  endtask

  int exp_out [4];

  task automatic run_layer(input bit b, input string tag);
    int nn = b ? 1 : 4;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int n = 0; n < nn; n++) begin
      expect_out(b, $sformatf("%s_n%0d", tag, n), 1, exp_out[n], n);
      @(negedge clk);
    end
    check({tag, "_done"}, dn(b), 1);
    @(negedge clk);
    check({tag, "_done_clr"}, dn(b), 0);
    check({tag, "_idle"}, by(b), 0);
  endtask

  typedef struct {
    int x0, x1, x2;
    int w0, w1, w2;
    int e_raw;
    int e_relu;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    tbl[0] = '{2, 3, 4, 5, 6, 7, 56, 56};
    tbl[1] = '{100, 100, 100, 100, 100, 100, 127, 127};
    tbl[2] = '{100, 100, 100, -100, -100, -100, -128, 0};
    tbl[3] = '{1, -2, 3, 4, 5, -6, -24, 0};
    tbl[4] = '{10, 10, 10, 4, 3, -1, 60, 60};
    tbl[5] = '{64, 64, 0, 1, 1, 0, 127, 127};
    tbl[6] = '{127, 0, 0, 1, 0, 0, 127, 127};
    tbl[7] = '{-64, -65, 0, 1, 1, 0, -128, 0};
    tbl[8] = '{-128, 0, 0, 1, 5, 5, -128, 0};
    tbl[9] = '{0, 0, 0, 9, 9, 9, 0, 0};

    start_a = 1'b0; start_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    load(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rd_en", rd_en_a, 0);
    check("rst_mac_clr", mac_clr_a, 0);
    check("rst_mac_en", mac_en_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_w_addr", w_addr_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy_a, 0);

    // Table: single-neuron raw saturation on B, four identical ReLU neurons on A.
    for (int v = 0; v < 10; v++) begin
      load(tbl[v].x0, tbl[v].x1, tbl[v].x2, tbl[v].w0, tbl[v].w1, tbl[v].w2);
      exp_out[0] = tbl[v].e_raw;
      run_layer(1'b1, $sformatf("vecB%0d", v));
      for (int n = 0; n < 4; n++) exp_out[n] = tbl[v].e_relu;
      run_layer(1'b0, $sformatf("vecA%0d", v));
    end

    // Distinct weight rows, start pulsed while issuing reads, single done pulse.
    x_mem[0] = 8'd1; x_mem[1] = 8'd1; x_mem[2] = 8'd1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) w_mem[r*3+c] = 8'(r + 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    expect_out(1'b0, "rows_n0", 3, 3, 0);
    @(negedge clk);
    for (int n = 1; n < 4; n++) begin
      expect_out(1'b0, $sformatf("rows_n%0d", n), 1, 3 * (n + 1), n);
      @(negedge clk);
    end
    dcnt = 0;
    for (int j = 0; j < 6; j++) begin
      dcnt += int'(done_a);
      @(negedge clk);
    end
    check("rows_done_count", dcnt, 1);

    // Backpressure: output held stable, no reads or MAC beats while stalled.
    out_ready_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    expect_out(1'b0, "stall_n0", 1, 3, 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("stall_valid", out_valid_a, 1);
      check("stall_data", $signed(out_data_a), 3);
      check("stall_idx", out_idx_a, 0);
      check("stall_rd_en", rd_en_a, 0);
      check("stall_mac_en", mac_en_a, 0);
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    check("stall_release", out_valid_a, 0);
    for (int n = 1; n < 4; n++) begin
      expect_out(1'b0, $sformatf("stall_n%0d", n), 1, 3 * (n + 1), n);
      @(negedge clk);
    end
    check("stall_done", done_a, 1);
    @(negedge clk);

    // Start held high: ignored while busy, relaunches only after IDLE.
    start_a = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      expect_out(1'b0, $sformatf("hold_n%0d", n), 1, 3 * (n + 1), n);
      @(negedge clk);
    end
    check("hold_done", done_a, 1);
    @(negedge clk);
    check("hold_idle_gap", busy_a, 0);
    @(negedge clk);
    check("hold_restart", busy_a, 1);
    check("hold_restart_clr", mac_clr_a, 1);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    check("wait_mac_en", mac_en_a, 1);
    check("wait_rd_en", rd_en_a, 0);

    // Asynchronous reset in WAIT: everything back to zero before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_mac_en", mac_en_a, 0);
    check("arst_out_data", out_data_a, 0);
    check("arst_out_idx", out_idx_a, 0);
    check("arst_x_addr", x_addr_a, 0);
    check("arst_w_addr", w_addr_a, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    dcnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      dcnt += int'(done_a) + int'(busy_a);
    end
    check("arst_no_done", dcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
